// File: rtl/wallace_mul_sched_if.sv
// Request/response bundle for wallace_mul_sched.
//   req0_*/req1_* : two requesters, valid/ready handshake, 16-bit operands, TAG_W tag
//   rsp_*         : product return, valid/ready handshake, product, source index, tag
// master: requesters + response consumer side; slave: the scheduler.
interface wallace_mul_sched_if #(
    parameter int unsigned TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [15:0]      req0_a;
    logic [15:0]      req0_b;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [15:0]      req1_a;
    logic [15:0]      req1_b;
    logic [TAG_W-1:0] req1_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_p;
    logic             rsp_src;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req0_valid, req0_a, req0_b, req0_tag,
        output req1_valid, req1_a, req1_b, req1_tag,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_p, rsp_src, rsp_tag
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_tag,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_p, rsp_src, rsp_tag
    );
endinterface

// File: rtl/wallace_mul_sched.sv
// Round-robin scheduler for a shared 16x16 Wallace partial-product accumulator.
//   clk, rst : clock, synchronous active-high reset
//   bus      : two request ports and one response port (wallace_mul_sched_if.slave)
//   pp_x     : 16 partial-product rows (row k at [32k+31:32k]) to the tree
//   ppa_s/c  : tree sum and weight-aligned carry vectors
//   busy     : high whenever a transaction is in flight
module wallace_mul_sched #(
    parameter int unsigned TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    wallace_mul_sched_if.slave  bus,
    output logic [511:0]        pp_x,
    input  logic [31:0]         ppa_s,
    input  logic [31:0]         ppa_c,
    output logic                busy
);
    localparam int unsigned OP_W = 16;
    localparam int unsigned P_W  = 32;
    localparam int unsigned ROWS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TREE = 2'd1,
        ADD  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state;
    logic             last_grant;
    logic [OP_W-1:0]  a_r;
    logic [OP_W-1:0]  b_r;
    logic [TAG_W-1:0] tag_r;
    logic             src_r;
    logic [P_W-1:0]   s_r;
    logic [P_W-1:0]   c_r;
    logic [P_W-1:0]   rsp_p_r;
    logic             rsp_src_r;
    logic [TAG_W-1:0] rsp_tag_r;

    logic grant0;
    logic grant1;

    // On a tie the requester not served last wins.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    end

    // Handshake and status decode; reset forces them quiet in the reset cycle too.
    assign bus.req0_ready = !rst && (state == IDLE) && grant0;
    assign bus.req1_ready = !rst && (state == IDLE) && grant1;
    assign bus.rsp_valid  = !rst && (state == RESP);
    assign busy           = !rst && (state != IDLE);
    assign bus.rsp_p      = rsp_p_r;
    assign bus.rsp_src    = rsp_src_r;
    assign bus.rsp_tag    = rsp_tag_r;

    // Partial-product rows from the latched operands only, so the tree path starts at flops.
    always_comb begin
        pp_x = '0;
        for (int k = 0; k < ROWS; k++) begin
            pp_x[P_W*k +: P_W] = b_r[k] ? (P_W'(a_r) << k) : '0;
        end
    end

    // Sequencer: accept, let the tree settle, final add, hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            a_r        <= '0;
            b_r        <= '0;
            tag_r      <= '0;
            src_r      <= 1'b0;
            s_r        <= '0;
            c_r        <= '0;
            rsp_p_r    <= '0;
            rsp_src_r  <= 1'b0;
            rsp_tag_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_r        <= grant1 ? bus.req1_a   : bus.req0_a;
                        b_r        <= grant1 ? bus.req1_b   : bus.req0_b;
                        tag_r      <= grant1 ? bus.req1_tag : bus.req0_tag;
                        src_r      <= grant1;
                        last_grant <= grant1;
                        state      <= TREE;
                    end
                end
                TREE: begin
                    s_r   <= ppa_s;
                    c_r   <= ppa_c;
                    state <= ADD;
                end
                ADD: begin
                    rsp_p_r   <= s_r + c_r;
                    rsp_src_r <= src_r;
                    rsp_tag_r <= tag_r;
                    state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
